rr_onehot_arbiter: RTL and testbench
====================================

Name: rr_onehot_arbiter

Overview:
- Round-robin arbiter that drives the one-hot `sel` input of the parametrised AND-OR selector.
- Up to `in_val` sources request the shared output; the block registers a one-hot grant and holds it until the owner releases.
- The grant guarantees the downstream wired-OR never sees more than one active select bit.
- Fairness: after every release, priority rotates to the index just above the last owner.

Parameters:
- in_val, 4, number of requesters; equals the selector's `in_val`, min 2
- idx_w, $clog2(in_val) (min 1), width of the binary grant index
- timeout, 16, max grant-hold cycles; used only when ARB_TIMEOUT_EN is defined, min 2

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req  input  in_val  request vector, bit i = source i wants the output
- done  input  1  owner finished; sampled only while grant_valid=1
- grant  output  in_val  registered one-hot grant, connects to selector `sel`; all-zero when idle
- grant_valid  output  1  high while any grant bit is set
- grant_idx  output  idx_w  binary index of the granted source; holds last value when idle
- timed_out  output  1  one-cycle pulse on forced release (constant 0 without ARB_TIMEOUT_EN)

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset: grant=0, grant_valid=0, grant_idx=0, timed_out=0, priority pointer ptr=0 (source 0 highest), state=IDLE, hold counter=0.
- All outputs are registered. No combinational path from req/done to grant.
- States:
  - IDLE: grant=0.
  - OWNED: exactly one grant bit set.
- IDLE -> OWNED:
  - Condition: edge where req != 0.
  - Winner: first set bit of req searching ptr, ptr+1, ..., in_val-1, 0, ..., ptr-1 (wrap-around).
  - Latency: req asserted in cycle N gives grant visible in cycle N+1.
- Release condition in OWNED (evaluated each edge): done=1, OR req[grant_idx]=0, OR (feature) hold counter reached timeout.
- On release:
  - ptr <= (grant_idx+1) mod in_val.
  - If req has bits set other than the releasing source, grant moves directly to the next winner in the same edge. The search starts at the new ptr, so there is no idle bubble.
  - If only the releasing source still requests, it is re-granted, still with no bubble.
  - If no other request exists, go to IDLE.
- No release: grant, grant_idx and ptr are held unchanged, regardless of other req changes.
- done while IDLE: ignored.
- done and the owner's req drop in the same cycle: treated as a single release.
- rst mid-ownership: grant drops to 0 on the next edge and ptr returns to 0; in-flight ownership is abandoned.
- Invariant: $countones(grant) <= 1 at every cycle. grant_valid == |grant.

Optional Feature:
- Macro: ARB_TIMEOUT_EN
- Defined:
  - Hold counter clears on each new grant (including re-grant) and increments each OWNED cycle.
  - When the counter reaches timeout-1 with no other release cause, ownership is forced off at that edge and normal re-arbitration follows.
  - timed_out pulses high for exactly one cycle, aligned with the new grant state.
  - A grant therefore lasts at most `timeout` cycles.
- Undefined:
  - No counter logic is built; timed_out is tied to 0.
  - Ownership is unbounded.

Test Plan:
- Reset, then in_val=4, req=4'b0000 for 5 cycles -> grant=0, grant_valid=0, grant_idx=0 throughout.
- req=4'b1010 held from cycle 0 after reset -> cycle 1 grant=4'b0010, idx=1. done pulse in cycle 3 -> cycle 4 grant=4'b1000, idx=3, no zero cycle between.
- Fairness: req=4'b1111 held, done pulsed every cycle -> grant sequence 0001, 0010, 0100, 1000, 0001 (wrap-around).
- Owner drops its req: owner idx=2 with req=4'b0100, then req goes to 4'b0000 -> next cycle grant=0, grant_valid=0; later req=4'b0101 -> grant=4'b0001 (ptr=3, wraps to 0).
- rst asserted while grant=4'b0100 -> next cycle grant=0, grant_valid=0; after rst low with req=4'b1100 -> grant=4'b0100 (ptr back to 0).
- With ARB_TIMEOUT_EN, timeout=4, req=4'b0011 held, done=0 -> grant=0001 for 4 cycles, then 0010 with timed_out high for 1 cycle. Without the macro -> grant stays 0001 indefinitely and timed_out=0.

Source files
------------

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter producing a registered one-hot grant for an AND-OR selector.
// Optional grant-hold timeout is built only when ARB_TIMEOUT_EN is defined.
module rr_onehot_arbiter #(
    parameter int in_val  = 4,
    parameter int idx_w   = (in_val > 1) ? $clog2(in_val) : 1,
    parameter int timeout = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [in_val-1:0] req,
    input  logic              done,
    output logic [in_val-1:0] grant,
    output logic              grant_valid,
    output logic [idx_w-1:0]  grant_idx,
    output logic              timed_out
);

    typedef enum logic {IDLE, OWNED} state_t;

    state_t             state_q, state_d;
    logic [in_val-1:0]  grant_q, grant_d;
    logic [idx_w-1:0]   idx_q, idx_d;
    logic [idx_w-1:0]   ptr_q, ptr_d;

    logic [idx_w-1:0]   next_ptr;
    logic [idx_w-1:0]   search_ptr;
    logic [idx_w:0]     pick_r;
    logic               owner_req;
    logic               early_rel;
    logic               hold_hit;
    logic               release_now;
    logic               grant_load;

    // Returns {found, index}: first set bit of r at or after p, wrapping around.
    function automatic logic [idx_w:0] pick(input logic [in_val-1:0] r,
                                            input logic [idx_w-1:0]  p);
        logic             found;
        logic [idx_w-1:0] win;
        int               j;
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < in_val; k++) begin
            j = int'(p) + k;
            if (j >= in_val) j = j - in_val;
            if (!found && r[j]) begin
                found = 1'b1;
                win   = idx_w'(j);
            end
        end
        return {found, win};
    endfunction

    assign next_ptr    = (idx_q == idx_w'(in_val - 1)) ? '0 : idx_q + 1'b1;
    assign owner_req   = req[idx_q];
    assign early_rel   = done || !owner_req;
    assign release_now = (state_q == OWNED) && (early_rel || hold_hit);
    assign search_ptr  = (state_q == OWNED) ? next_ptr : ptr_q;
    assign pick_r      = pick(req, search_ptr);

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        idx_d      = idx_q;
        ptr_d      = ptr_q;
        grant_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_r[idx_w]) begin
                    state_d    = OWNED;
                    grant_load = 1'b1;
                end
            end
            OWNED: begin
                if (release_now) begin
                    ptr_d = next_ptr;
                    if (pick_r[idx_w]) begin
                        grant_load = 1'b1;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
        if (grant_load) begin
            idx_d          = pick_r[idx_w-1:0];
            grant_d        = '0;
            grant_d[idx_d] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int hold_w = (timeout > 2) ? $clog2(timeout) : 1;

    logic [hold_w-1:0] hold_q, hold_d;
    logic              timed_out_q, timed_out_d;

    assign hold_hit = (state_q == OWNED) && (hold_q == hold_w'(timeout - 1));

    // Counter stays below timeout-1 except at the forced-release edge.
    always_comb begin
        hold_d      = hold_q;
        timed_out_d = release_now && hold_hit && !early_rel;
        if (grant_load) begin
            hold_d = '0;
        end else if (state_q == OWNED) begin
            hold_d = hold_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q      <= '0;
            timed_out_q <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            timed_out_q <= timed_out_d;
        end
    end

    assign timed_out = timed_out_q;
`else
    assign hold_hit  = 1'b0;
    assign timed_out = 1'b0;
`endif

    assign grant       = grant_q;
    assign grant_valid = (state_q == OWNED);
    assign grant_idx   = idx_q;

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Directed bench for rr_onehot_arbiter (in_val=4, timeout=4); timeout cases follow ARB_TIMEOUT_EN.
module tb_rr_onehot_arbiter;

    localparam int N = 4;

    logic         clk;
    logic         rst;
    logic [N-1:0] req;
    logic         done;
    logic [N-1:0] grant;
    logic         grant_valid;
    logic [1:0]   grant_idx;
    logic         timed_out;

    int n_checks = 0;
    int n_errors = 0;

    rr_onehot_arbiter #(.in_val(N), .timeout(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .timed_out   (timed_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are read 1 ns later, inputs changed there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_grant(input string tag, input logic [N-1:0] g, input logic [1:0] idx,
                                input logic tmo);
        check({tag, ".grant"}, 32'(grant), 32'(g));
        check({tag, ".valid"}, 32'(grant_valid), 32'(g != '0));
        check({tag, ".idx"}, 32'(grant_idx), 32'(idx));
        check({tag, ".tmo"}, 32'(timed_out), 32'(tmo));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst  = 1'b0;
        req  = '0;
        done = 1'b0;
        #1;
        do_reset();

        // Idle with no requests
        expect_grant("rst", 4'b0000, 2'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_grant("idle", 4'b0000, 2'd0, 1'b0);
        end

        // Handover on done without a bubble
        req = 4'b1010;
        tick();
        expect_grant("h_first", 4'b0010, 2'd1, 1'b0);
        tick();
        expect_grant("h_hold1", 4'b0010, 2'd1, 1'b0);
        done = 1'b1;
        tick();
        done = 1'b0;
        expect_grant("h_next", 4'b1000, 2'd3, 1'b0);
        tick();
        expect_grant("h_hold2", 4'b1000, 2'd3, 1'b0);

        // Fairness with all requesting and done held (ignored while idle)
        do_reset();
        req  = 4'b1111;
        done = 1'b1;
        tick();
        expect_grant("rr0", 4'b0001, 2'd0, 1'b0);
        tick();
        expect_grant("rr1", 4'b0010, 2'd1, 1'b0);
        tick();
        expect_grant("rr2", 4'b0100, 2'd2, 1'b0);
        tick();
        expect_grant("rr3", 4'b1000, 2'd3, 1'b0);
        tick();
        expect_grant("rr_wrap", 4'b0001, 2'd0, 1'b0);
        done = 1'b0;

        // Owner drops request -> idle; pointer then wraps from 3 to 0
        do_reset();
        req = 4'b0100;
        tick();
        expect_grant("drop_own", 4'b0100, 2'd2, 1'b0);
        req = 4'b0000;
        tick();
        expect_grant("drop_idle", 4'b0000, 2'd2, 1'b0);
        req = 4'b0101;
        tick();
        expect_grant("drop_wrap", 4'b0001, 2'd0, 1'b0);

        // done and req drop together count as one release
        req  = 4'b0100;
        done = 1'b1;
        tick();
        done = 1'b0;
        expect_grant("dual_rel", 4'b0100, 2'd2, 1'b0);

        // Reset mid-ownership abandons the grant and the pointer
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_grant("mid_rst", 4'b0000, 2'd0, 1'b0);
        req = 4'b1100;
        tick();
        expect_grant("post_rst", 4'b0100, 2'd2, 1'b0);

        // Hold limit
        do_reset();
        req = 4'b0011;
        tick();
        expect_grant("to_first", 4'b0001, 2'd0, 1'b0);
`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_grant("to_hold", 4'b0001, 2'd0, 1'b0);
        end
        tick();
        expect_grant("to_force", 4'b0010, 2'd1, 1'b1);
        tick();
        expect_grant("to_after", 4'b0010, 2'd1, 1'b0);
`else
        for (int i = 0; i < 8; i++) begin
            tick();
            expect_grant("no_to_hold", 4'b0001, 2'd0, 1'b0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
